// File: rtl/mux_2_1.sv
// -----------------------------------------------------------------------------
// mux_2_1
//   Registered, parameterizable 2:1 lane-select multiplexer. Two data lanes
//   arrive packed on one ascending-indexed bus; the selected lane is pushed
//   through LATENCY register stages together with a valid flag.
//
// Parameters
//   WIDTH     bit width of each lane (1..64)
//   LATENCY   register stages from input sample edge to y/out_valid (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every pipeline stage
//   d          packed lanes [0:2*WIDTH-1]; lane 0 = d[0:WIDTH-1],
//              lane 1 = d[WIDTH:2*WIDTH-1] (lane 0 is the leftmost literal part)
//   s          select: 0 -> lane 0, 1 -> lane 1
//   in_valid   qualifies d/s in the current cycle
//   y          selected lane, registered
//   out_valid  y holds a result produced from a valid input
// -----------------------------------------------------------------------------
module mux_2_1 #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:2*WIDTH-1]   d,
    input  logic                 s,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     y,
    output logic                 out_valid
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("mux_2_1: WIDTH must be in 1..64");
        end
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("mux_2_1: LATENCY must be in 1..4");
        end
    endgenerate

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] sel;

    // Slices keep literal order: the leftmost bit of each lane lands in the
    // MSB of the descending result.
    assign lane0 = d[0:WIDTH-1];
    assign lane1 = d[WIDTH:2*WIDTH-1];

    // An unknown select falls into the default branch, so simulation shows X
    // on the data path instead of quietly picking a lane; synthesis sees only
    // the two binary cases.
    always_comb begin
        sel = '0;
        case (s)
            1'b0:    sel = lane0;
            1'b1:    sel = lane1;
            default: sel = 'x;
        endcase
    end

    logic [WIDTH-1:0] data_q [LATENCY];
    logic [LATENCY-1:0] valid_q;

    // Data stages load every cycle regardless of in_valid; only the valid
    // flag tells the consumer whether y means anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= sel;
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign y         = data_q[LATENCY-1];
    assign out_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_mux_2_1.sv
// -----------------------------------------------------------------------------
// tb_mux_2_1
//   Two instances: WIDTH=1/LATENCY=1 and WIDTH=8/LATENCY=3, sharing clock,
//   reset, select and valid. Stimulus is applied on the falling edge and the
//   expected result for each capture edge is queued with the cycle it must
//   appear on; a monitor checks both outputs 1 ns after every rising edge.
// -----------------------------------------------------------------------------
module tb_mux_2_1;

    localparam int L1 = 1;
    localparam int L8 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  d1;
    logic [15:0] d8;
    logic        s;
    logic        in_valid;
    logic        y1;
    logic        ov1;
    logic [7:0]  y8;
    logic        ov8;

    always #5 clk = ~clk;

    mux_2_1 #(.WIDTH(1), .LATENCY(L1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .d(d1), .s(s), .in_valid(in_valid),
        .y(y1), .out_valid(ov1)
    );

    mux_2_1 #(.WIDTH(8), .LATENCY(L8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .d(d8), .s(s), .in_valid(in_valid),
        .y(y8), .out_valid(ov8)
    );

    typedef struct {
        int         due;
        logic       v;
        logic [7:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference: lane 0 is the left half of the literal, lane 1 the right half.
    function automatic logic [7:0] ref_sel8(input logic [15:0] dv, input logic sv);
        return sv ? dv[7:0] : dv[15:8];
    endfunction

    function automatic logic ref_sel1(input logic [1:0] dv, input logic sv);
        return sv ? dv[0] : dv[1];
    endfunction

    // Apply one cycle of stimulus; anything captured with reset high is queued.
    task automatic drive(input logic r, input logic [1:0] dv1, input logic [15:0] dv8,
                         input logic sv, input logic vv);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        d1       = dv1;
        d8       = dv8;
        s        = sv;
        in_valid = vv;
        if (!r) begin
            q1.delete();
            q8.delete();
        end else begin
            e.due  = cyc + L1;
            e.v    = vv;
            e.data = {7'd0, ref_sel1(dv1, sv)};
            q1.push_back(e);
            e.due  = cyc + L8;
            e.data = ref_sel8(dv8, sv);
            q8.push_back(e);
        end
    endtask

    task automatic drive_rand(input logic r);
        drive(r, 2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Monitor: one expected record per cycle per instance; a cycle with no
    // record due is the post-reset fill, where the reset value must still show.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst_n) begin
            cmp("rst_y1", {15'd0, y1}, 16'd0);
            cmp("rst_v1", {15'd0, ov1}, 16'd0);
            cmp("rst_y8", {8'd0, y8}, 16'd0);
            cmp("rst_v8", {15'd0, ov8}, 16'd0);
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                cmp("valid1", {15'd0, ov1}, {15'd0, e.v});
                if (e.v) cmp("data1", {15'd0, y1}, {15'd0, e.data[0]});
            end else begin
                cmp("fill_v1", {15'd0, ov1}, 16'd0);
                cmp("fill_y1", {15'd0, y1}, 16'd0);
            end
            if (q8.size() > 0 && q8[0].due == cyc) begin
                e = q8.pop_front();
                cmp("valid8", {15'd0, ov8}, {15'd0, e.v});
                if (e.v) cmp("data8", {8'd0, y8}, {8'd0, e.data});
            end else begin
                cmp("fill_v8", {15'd0, ov8}, 16'd0);
                cmp("fill_y8", {8'd0, y8}, 16'd0);
            end
        end
    end

    initial begin
        logic [1:0] tt_d [4];
        logic       tt_s [4];
        rst_n    = 1'b0;
        d1       = '0;
        d8       = '0;
        s        = 1'b0;
        in_valid = 1'b0;
        tt_d[0] = 2'b01; tt_s[0] = 1'b0;
        tt_d[1] = 2'b01; tt_s[1] = 1'b1;
        tt_d[2] = 2'b10; tt_s[2] = 1'b0;
        tt_d[3] = 2'b10; tt_s[3] = 1'b1;

        // Held in reset while inputs toggle.
        repeat (6) drive_rand(1'b0);

        // Truth table on the 1-bit instance, each vector held 100 ns.
        for (int i = 0; i < 4; i++) begin
            repeat (10) drive(1'b1, tt_d[i], 16'($urandom), tt_s[i], 1'b1);
        end

        // Single valid pulse through the 3-stage instance.
        drive(1'b1, 2'b01, 16'hA53C, 1'b1, 1'b1);
        repeat (6) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Back-to-back alternating select.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'($urandom), 16'hFF00, 1'(i % 2), 1'b1);
        end

        // Two-cycle valid gap mid-stream.
        repeat (4) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        repeat (2) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        repeat (4) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b1);

        // Reset mid-stream, asserted between clock edges.
        drive(1'b1, 2'b10, 16'h5AC3, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 16'h9966, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q1.delete();
        q8.delete();
        #1;
        cmp("async_y1", {15'd0, y1}, 16'd0);
        cmp("async_v1", {15'd0, ov1}, 16'd0);
        cmp("async_y8", {8'd0, y8}, 16'd0);
        cmp("async_v8", {15'd0, ov8}, 16'd0);
        repeat (3) drive_rand(1'b0);
        repeat (2) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        repeat (4) drive(1'b1, 2'($urandom), 16'($urandom), 1'($urandom), 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive_rand(($urandom_range(0, 24) != 0) ? 1'b1 : 1'b0);
        end

        // Quiet tail: zero data so post-stimulus captures match the fill rule.
        repeat (4) drive(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        cmp("drain_q1", 16'(q1.size()), 16'd0);
        cmp("drain_q8", 16'(q8.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
